// File: rtl/rf_mp.sv
// Parametrised multi-port register file with write-to-read bypass, busy scoreboard,
// auto-incrementing instruction pointer, hardwired zero register and flags register.
module rf_mp #(
  parameter int WORD_WIDTH    = 32,
  parameter int ADDRESS_WIDTH = 5,
  parameter int READ_PORTS    = 10,
  parameter int WRITE_PORTS   = 4,
  parameter int IP_OFFSET     = 2,
  parameter int FLAGS_ADDR    = 1,
  parameter int IP_STEP       = 4,
  parameter int ZERO_REG      = 1
) (
  input  logic                                          clk_i,
  input  logic                                          arst_ni,
  input  logic [READ_PORTS-1:0][ADDRESS_WIDTH-1:0]      rd_addr_i,
  output logic [READ_PORTS-1:0][WORD_WIDTH-1:0]         rd_data_o,
  output logic [READ_PORTS-1:0]                         rd_busy_o,
  input  logic [WRITE_PORTS-1:0]                        wr_en_i,
  input  logic [WRITE_PORTS-1:0][ADDRESS_WIDTH-1:0]     wr_addr_i,
  input  logic [WRITE_PORTS-1:0][WORD_WIDTH-1:0]        wr_data_i,
  input  logic                                          reserve_en_i,
  input  logic [ADDRESS_WIDTH-1:0]                      reserve_addr_i,
  input  logic                                          ip_inc_i,
  input  logic                                          flags_we_i,
  input  logic [WORD_WIDTH-1:0]                         flags_i,
  output logic [WORD_WIDTH-1:0]                         instr_ptr_o,
  output logic [WORD_WIDTH-1:0]                         flags_o,
  output logic [(2**ADDRESS_WIDTH)-1:0]                 busy_o,
  output logic                                          conflict_o
);

  localparam int NREGS = 2**ADDRESS_WIDTH;
  localparam logic [ADDRESS_WIDTH-1:0] IP_A    = ADDRESS_WIDTH'(IP_OFFSET);
  localparam logic [ADDRESS_WIDTH-1:0] FLAGS_A = ADDRESS_WIDTH'(FLAGS_ADDR);
  localparam logic                     HAS_ZERO = (ZERO_REG != 0);

  logic [NREGS-1:0][WORD_WIDTH-1:0] regs_q, regs_d;
  logic [NREGS-1:0]                 busy_q, busy_d;
  logic                             conflict_q, conflict_d;

  logic [NREGS-1:0]                 wr_hit;
  logic [NREGS-1:0][WORD_WIDTH-1:0] wr_val;
  logic [WRITE_PORTS-1:0]           wr_valid;
  logic                             res_valid;

  // Ascending port scan: a later (higher) port overwrites, so the highest index wins.
  always_comb begin
    wr_hit     = '0;
    wr_val     = '0;
    wr_valid   = '0;
    conflict_d = 1'b0;
    for (int p = 0; p < WRITE_PORTS; p++) begin
      wr_valid[p] = wr_en_i[p] && !(HAS_ZERO && (wr_addr_i[p] == '0));
      if (wr_valid[p]) begin
        if (wr_hit[wr_addr_i[p]]) conflict_d = 1'b1;
        wr_hit[wr_addr_i[p]] = 1'b1;
        wr_val[wr_addr_i[p]] = wr_data_i[p];
      end
    end
  end

  assign res_valid = reserve_en_i && !(HAS_ZERO && (reserve_addr_i == '0));

  always_comb begin
    regs_d = regs_q;
    busy_d = busy_q;
    for (int a = 0; a < NREGS; a++) begin
      if (wr_hit[a]) begin
        regs_d[a] = wr_val[a];
        busy_d[a] = 1'b0;
      end
    end
    if (!wr_hit[IP_A] && ip_inc_i) regs_d[IP_A] = regs_q[IP_A] + WORD_WIDTH'(IP_STEP);
    if (!wr_hit[FLAGS_A] && flags_we_i) regs_d[FLAGS_A] = flags_i;
    // A reservation landing with a write to the same register is the newer producer.
    if (res_valid) busy_d[reserve_addr_i] = 1'b1;
    if (HAS_ZERO) begin
      regs_d[0] = '0;
      busy_d[0] = 1'b0;
    end
  end

  always_comb begin
    rd_data_o = '0;
    rd_busy_o = '0;
    for (int r = 0; r < READ_PORTS; r++) begin
      rd_data_o[r] = wr_hit[rd_addr_i[r]] ? wr_val[rd_addr_i[r]] : regs_q[rd_addr_i[r]];
      rd_busy_o[r] = busy_q[rd_addr_i[r]] &&
                     !(wr_hit[rd_addr_i[r]] && !(res_valid && (reserve_addr_i == rd_addr_i[r])));
      if (HAS_ZERO && (rd_addr_i[r] == '0)) begin
        rd_data_o[r] = '0;
        rd_busy_o[r] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      regs_q     <= '0;
      busy_q     <= '0;
      conflict_q <= 1'b0;
    end else begin
      regs_q     <= regs_d;
      busy_q     <= busy_d;
      conflict_q <= conflict_d;
    end
  end

  assign instr_ptr_o = regs_q[IP_A];
  assign flags_o     = regs_q[FLAGS_A];
  assign busy_o      = busy_q;
  assign conflict_o  = conflict_q;

endmodule

// File: tb/tb_rf_mp.sv
// Bench for rf_mp: directed scenarios then random traffic against a behavioural model.
module tb_rf_mp;
  localparam int W  = 32;
  localparam int AW = 5;
  localparam int RP = 10;
  localparam int WP = 4;
  localparam int NR = 32;

  logic                    clk_i = 1'b0;
  logic                    arst_ni;
  logic [RP-1:0][AW-1:0]   rd_addr_i;
  logic [RP-1:0][W-1:0]    rd_data_o;
  logic [RP-1:0]           rd_busy_o;
  logic [WP-1:0]           wr_en_i;
  logic [WP-1:0][AW-1:0]   wr_addr_i;
  logic [WP-1:0][W-1:0]    wr_data_i;
  logic                    reserve_en_i;
  logic [AW-1:0]           reserve_addr_i;
  logic                    ip_inc_i;
  logic                    flags_we_i;
  logic [W-1:0]            flags_i;
  logic [W-1:0]            instr_ptr_o;
  logic [W-1:0]            flags_o;
  logic [NR-1:0]           busy_o;
  logic                    conflict_o;

  rf_mp dut (
    .clk_i(clk_i), .arst_ni(arst_ni),
    .rd_addr_i(rd_addr_i), .rd_data_o(rd_data_o), .rd_busy_o(rd_busy_o),
    .wr_en_i(wr_en_i), .wr_addr_i(wr_addr_i), .wr_data_i(wr_data_i),
    .reserve_en_i(reserve_en_i), .reserve_addr_i(reserve_addr_i),
    .ip_inc_i(ip_inc_i), .flags_we_i(flags_we_i), .flags_i(flags_i),
    .instr_ptr_o(instr_ptr_o), .flags_o(flags_o), .busy_o(busy_o), .conflict_o(conflict_o)
  );

  always #5 clk_i = ~clk_i;

  int n_checks = 0;
  int n_fail   = 0;

  // Architectural state as the core sees it.
  logic [W-1:0] m_regs [NR];
  logic         m_busy [NR];
  logic         m_conflict;

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int a = 0; a < NR; a++) begin
      m_regs[a] = '0;
      m_busy[a] = 1'b0;
    end
    m_conflict = 1'b0;
  endtask

  // Highest-numbered enabled port targeting a, or -1; register 0 never accepts writes.
  function automatic int winner(input int a);
    if (a == 0) return -1;
    for (int p = WP - 1; p >= 0; p--)
      if (wr_en_i[p] && int'(wr_addr_i[p]) == a) return p;
    return -1;
  endfunction

  function automatic logic [W-1:0] exp_rd(input int a);
    int w;
    if (a == 0) return '0;
    w = winner(a);
    if (w >= 0) return wr_data_i[w];
    return m_regs[a];
  endfunction

  function automatic logic exp_busy(input int a);
    if (a == 0) return 1'b0;
    if (winner(a) >= 0 && !(reserve_en_i && int'(reserve_addr_i) == a)) return 1'b0;
    return m_busy[a];
  endfunction

  task automatic model_commit();
    logic [W-1:0] nr [NR];
    logic         nb [NR];
    logic         nc;
    int           cnt, w;
    nc = 1'b0;
    for (int a = 0; a < NR; a++) begin
      nr[a] = m_regs[a];
      nb[a] = m_busy[a];
    end
    for (int a = 1; a < NR; a++) begin
      cnt = 0;
      for (int p = 0; p < WP; p++) if (wr_en_i[p] && int'(wr_addr_i[p]) == a) cnt++;
      if (cnt >= 2) nc = 1'b1;
      w = winner(a);
      if (w >= 0) begin
        nr[a] = wr_data_i[w];
        nb[a] = 1'b0;
      end
    end
    if (winner(2) < 0 && ip_inc_i) nr[2] = m_regs[2] + 32'd4;
    if (winner(1) < 0 && flags_we_i) nr[1] = flags_i;
    if (reserve_en_i && reserve_addr_i != 0) nb[reserve_addr_i] = 1'b1;
    for (int a = 0; a < NR; a++) begin
      m_regs[a] = nr[a];
      m_busy[a] = nb[a];
    end
    m_conflict = nc;
  endtask

  task automatic check_comb();
    for (int r = 0; r < RP; r++) begin
      check($sformatf("rd_data[%0d]", r), rd_data_o[r], exp_rd(int'(rd_addr_i[r])));
      check($sformatf("rd_busy[%0d]", r), {31'd0, rd_busy_o[r]}, {31'd0, exp_busy(int'(rd_addr_i[r]))});
    end
  endtask

  task automatic check_regs();
    logic [NR-1:0] bv;
    for (int a = 0; a < NR; a++) bv[a] = m_busy[a];
    check("instr_ptr", instr_ptr_o, m_regs[2]);
    check("flags", flags_o, m_regs[1]);
    check("busy_vec", busy_o, bv);
    check("conflict", {31'd0, conflict_o}, {31'd0, m_conflict});
  endtask

  // Called at posedge+1 with inputs already applied.
  task automatic tick();
    #1 check_comb();
    @(posedge clk_i);
    model_commit();
    #1 check_regs();
  endtask

  task automatic clr_inputs();
    wr_en_i = '0; wr_addr_i = '0; wr_data_i = '0;
    reserve_en_i = 1'b0; reserve_addr_i = '0;
    ip_inc_i = 1'b0; flags_we_i = 1'b0; flags_i = '0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    clr_inputs();
    rd_addr_i = '0;
    arst_ni = 1'b0;
    model_reset();
    @(negedge clk_i);
    arst_ni = 1'b1;
    @(posedge clk_i);
    model_commit();
    #1 check_regs();

    // 1: build some state, then reset mid-cycle with a write pending
    wr_en_i[0] = 1'b1; wr_addr_i[0] = 5'd3; wr_data_i[0] = 32'h11;
    reserve_en_i = 1'b1; reserve_addr_i = 5'd9;
    ip_inc_i = 1'b1; flags_we_i = 1'b1; flags_i = 32'h7;
    tick();
    clr_inputs();
    wr_en_i[0] = 1'b1; wr_addr_i[0] = 5'd4; wr_data_i[0] = 32'h99;
    #2 arst_ni = 1'b0;
    model_reset();
    #1 check_regs();
    check("t1_ip_zero", instr_ptr_o, 32'h0);
    @(posedge clk_i);
    #1 check_regs();
    wr_en_i = '0;
    for (int r = 0; r < RP; r++) rd_addr_i[r] = AW'(r + 1);
    #1 check_comb();
    check("t1_rd3_zero", rd_data_o[2], 32'h0);
    @(negedge clk_i);
    arst_ni = 1'b1;
    wr_en_i[0] = 1'b1; wr_addr_i[0] = 5'd3; wr_data_i[0] = 32'h55;
    tick();
    clr_inputs();
    rd_addr_i[0] = 5'd3;
    #1 check("t1_rd3", rd_data_o[0], 32'h55);

    // 2: four-way write conflict on one address
    for (int p = 0; p < WP; p++) begin
      wr_en_i[p] = 1'b1; wr_addr_i[p] = 5'd5; wr_data_i[p] = W'(p + 1);
    end
    rd_addr_i[0] = 5'd5;
    #1 check("t2_bypass", rd_data_o[0], 32'h4);
    tick();
    check("t2_conflict_hi", {31'd0, conflict_o}, 32'h1);
    clr_inputs();
    tick();
    check("t2_conflict_lo", {31'd0, conflict_o}, 32'h0);
    check("t2_stored", rd_data_o[0], 32'h4);

    // 3: same-cycle bypass, and writes to register 0 are dropped
    wr_en_i[1] = 1'b1; wr_addr_i[1] = 5'd7; wr_data_i[1] = 32'hAA;
    rd_addr_i[0] = 5'd7;
    #1 check("t3_bypass", rd_data_o[0], 32'hAA);
    tick();
    clr_inputs();
    wr_en_i[0] = 1'b1; wr_addr_i[0] = 5'd0; wr_data_i[0] = 32'hFF;
    wr_en_i[2] = 1'b1; wr_addr_i[2] = 5'd0; wr_data_i[2] = 32'hEE;
    rd_addr_i[0] = 5'd0;
    tick();
    check("t3_zero_rd", rd_data_o[0], 32'h0);
    check("t3_zero_noconf", {31'd0, conflict_o}, 32'h0);

    // 4: IP wrap and port-write priority over increment
    clr_inputs();
    wr_en_i[0] = 1'b1; wr_addr_i[0] = 5'd2; wr_data_i[0] = 32'hFFFF_FFFC;
    tick();
    clr_inputs();
    ip_inc_i = 1'b1;
    tick();
    check("t4_wrap", instr_ptr_o, 32'h0);
    wr_en_i[3] = 1'b1; wr_addr_i[3] = 5'd2; wr_data_i[3] = 32'h100;
    tick();
    check("t4_prio", instr_ptr_o, 32'h100);

    // 5: scoreboard
    clr_inputs();
    reserve_en_i = 1'b1; reserve_addr_i = 5'd9;
    tick();
    check("t5_busy_set", {31'd0, busy_o[9]}, 32'h1);
    clr_inputs();
    wr_en_i[2] = 1'b1; wr_addr_i[2] = 5'd9; wr_data_i[2] = 32'h9;
    rd_addr_i[1] = 5'd9;
    #1 check("t5_rd_busy_byp", {31'd0, rd_busy_o[1]}, 32'h0);
    tick();
    check("t5_busy_clr", {31'd0, busy_o[9]}, 32'h0);
    reserve_en_i = 1'b1; reserve_addr_i = 5'd9;
    tick();
    check("t5_busy_both", {31'd0, busy_o[9]}, 32'h1);

    // 6: flags priority
    clr_inputs();
    flags_we_i = 1'b1; flags_i = 32'h3;
    wr_en_i[0] = 1'b1; wr_addr_i[0] = 5'd1; wr_data_i[0] = 32'h8;
    tick();
    check("t6_port_wins", flags_o, 32'h8);
    wr_en_i = '0;
    tick();
    check("t6_side", flags_o, 32'h3);

    // Random traffic concentrated on a few registers to provoke conflicts and bypasses
    for (int i = 0; i < 400; i++) begin
      for (int p = 0; p < WP; p++) begin
        wr_en_i[p]   = ($urandom_range(0, 2) != 0);
        wr_addr_i[p] = ($urandom_range(0, 3) == 0) ? AW'($urandom) : AW'($urandom_range(0, 10));
        wr_data_i[p] = $urandom;
      end
      for (int r = 0; r < RP; r++)
        rd_addr_i[r] = ($urandom_range(0, 3) == 0) ? AW'($urandom) : AW'($urandom_range(0, 10));
      reserve_en_i   = ($urandom_range(0, 1) == 1);
      reserve_addr_i = AW'($urandom_range(0, 10));
      ip_inc_i       = ($urandom_range(0, 1) == 1);
      flags_we_i     = ($urandom_range(0, 2) == 0);
      flags_i        = $urandom;
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
